// File: rtl/accessor.sv
// rtl/accessor.sv - memory-access pipeline stage between executor and writeback
// Single-outstanding native bus; loads are aligned and extended, stores write x0.
module accessor (
   input  logic        clk,
   input  logic        reset,
   input  logic        executor_valid,
   output logic        accessor_ready,
   input  logic [1:0]  in_op,
   input  logic [1:0]  in_width,
   input  logic        in_unsigned,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_rd_data,
   input  logic [31:0] in_mem_addr,
   input  logic [31:0] in_mem_data,
   output logic        accessor_valid,
   input  logic        writeback_ready,
   output logic [4:0]  out_rd,
   output logic [31:0] out_rd_data,
   output logic        fault,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MEM  = 1'b1;

   logic [0:0]  r_state;
   logic        r_is_load;
   logic [1:0]  r_width;
   logic        r_unsigned;
   logic [4:0]  r_rd;
   logic [1:0]  r_addr_lo;
   logic        r_valid;
   logic        r_fault;
   logic [4:0]  r_out_rd;
   logic [31:0] r_out_data;
   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;

   logic        w_accept;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_misaligned;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   assign accessor_ready = (r_state == S_IDLE) && (!r_valid || writeback_ready);
   assign w_accept       = executor_valid && accessor_ready;
   assign w_is_load      = (in_op == 2'b01);
   assign w_is_store     = (in_op == 2'b10);
   // Width 11 behaves as word, so only bit 1 distinguishes word from half.
   assign w_misaligned   = ((in_width == 2'b01) && in_mem_addr[0]) ||
                           (in_width[1] && (in_mem_addr[1:0] != 2'b00));

   always_comb begin
      w_wdata = in_mem_data;
      w_wstrb = 4'b1111;
      case (in_width)
         2'b00: begin
            w_wdata = {4{in_mem_data[7:0]}};
            w_wstrb = 4'b0001 << in_mem_addr[1:0];
         end
         2'b01: begin
            w_wdata = {2{in_mem_data[15:0]}};
            w_wstrb = 4'b0011 << {in_mem_addr[1], 1'b0};
         end
         default: begin
            w_wdata = in_mem_data;
            w_wstrb = 4'b1111;
         end
      endcase
   end

   assign w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
   assign w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = mem_rdata;
      case (r_width)
         2'b00:   w_load_data = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load_data = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_is_load   <= 1'b0;
         r_width     <= 2'b00;
         r_unsigned  <= 1'b0;
         r_rd        <= 5'd0;
         r_addr_lo   <= 2'b00;
         r_valid     <= 1'b0;
         r_fault     <= 1'b0;
         r_out_rd    <= 5'd0;
         r_out_data  <= 32'd0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_wstrb <= 4'b0000;
      end else if (r_state == S_MEM) begin
         // Output register is always empty here: entering MEM drained it.
         if (mem_ready) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_valid     <= 1'b1;
            r_fault     <= 1'b0;
            r_out_rd    <= r_is_load ? r_rd : 5'd0;
            r_out_data  <= r_is_load ? w_load_data : 32'd0;
         end
      end else if (w_accept) begin
         r_is_load  <= w_is_load;
         r_width    <= in_width;
         r_unsigned <= in_unsigned;
         r_rd       <= in_rd;
         r_addr_lo  <= in_mem_addr[1:0];
         if (!(w_is_load || w_is_store)) begin
            r_valid    <= 1'b1;
            r_fault    <= 1'b0;
            r_out_rd   <= in_rd;
            r_out_data <= in_rd_data;
         end else if (w_misaligned) begin
            r_valid    <= 1'b1;
            r_fault    <= 1'b1;
            r_out_rd   <= 5'd0;
            r_out_data <= 32'd0;
         end else begin
            r_state     <= S_MEM;
            r_valid     <= 1'b0;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= {in_mem_addr[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= w_is_store ? w_wstrb : 4'b0000;
         end
      end else if (r_valid && writeback_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign accessor_valid = r_valid;
   assign fault          = r_fault;
   assign out_rd         = r_out_rd;
   assign out_rd_data    = r_out_data;
   assign mem_valid      = r_mem_valid;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign mem_wstrb      = r_mem_wstrb;

endmodule
